// File: rtl/gtech_pkg.sv
// Shared constants and helpers for the gtech_* pipeline blocks.
// Parameter limits live here so every block checks against the same bounds.
package gtech_pkg;

    localparam int GTECH_MAX_WIDTH  = 64;
    localparam int GTECH_MAX_STAGES = 4;

    function automatic bit gtech_in_range(input int value, input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/gtech_andnot_stage.sv
// One elastic pipeline stage: a valid bit plus a data word.
// The stage can take new data while its current content leaves in the same cycle.
module gtech_andnot_stage
    import gtech_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_vld_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_rdy_o,
    output logic             out_vld_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_rdy_i
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             doLoad;
    logic             doAdvance;

    // Data is held once the stage empties so the output stays quiet between items.
    always_comb begin
        doAdvance = valid_q & out_rdy_i;
        in_rdy_o  = ~valid_q | out_rdy_i;
        doLoad    = in_vld_i & in_rdy_o;
        valid_d   = valid_q;
        data_d    = data_q;
        if (doLoad) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (doAdvance) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_vld_o  = valid_q;
    assign out_data_o = data_q;

endmodule

// File: rtl/gtech_andnot_pipe.sv
// Elastic pipeline computing Z = A & ~B, with an optional sticky OR of every
// result handed to the consumer.
module gtech_andnot_pipe
    import gtech_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int STAGES    = 2,
    parameter bit STICKY_EN = 1'b1
) (
    input  logic             CP,
    input  logic             CD,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             IN_VLD,
    output logic             IN_RDY,
    output logic [WIDTH-1:0] Z,
    output logic             OUT_VLD,
    input  logic             OUT_RDY,
    input  logic             CLR,
    output logic [WIDTH-1:0] STK,
    output logic             ANY
);

    if (!gtech_in_range(WIDTH, 1, GTECH_MAX_WIDTH)) begin : gBadWidth
        $error("gtech_andnot_pipe: WIDTH must lie in 1..%0d", GTECH_MAX_WIDTH);
    end
    if (!gtech_in_range(STAGES, 1, GTECH_MAX_STAGES)) begin : gBadStages
        $error("gtech_andnot_pipe: STAGES must lie in 1..%0d", GTECH_MAX_STAGES);
    end

    // Index 0 is the input port side, index STAGES the output port side.
    logic             stgVld  [STAGES+1];
    logic [WIDTH-1:0] stgData [STAGES+1];
    logic             stgRdy  [STAGES+1];
    logic             delivery;

    assign stgVld[0]      = IN_VLD;
    assign stgData[0]     = A & ~B;
    assign IN_RDY         = stgRdy[0];
    assign stgRdy[STAGES] = OUT_RDY;
    assign OUT_VLD        = stgVld[STAGES];
    assign Z              = stgData[STAGES];
    assign delivery       = OUT_VLD & OUT_RDY;

    for (genvar i = 0; i < STAGES; i++) begin : gStage
        gtech_andnot_stage #(
            .WIDTH(WIDTH)
        ) uStage (
            .clk_i     (CP),
            .rst_n_i   (CD),
            .in_vld_i  (stgVld[i]),
            .in_data_i (stgData[i]),
            .in_rdy_o  (stgRdy[i]),
            .out_vld_o (stgVld[i+1]),
            .out_data_o(stgData[i+1]),
            .out_rdy_i (stgRdy[i+1])
        );
    end

    if (STICKY_EN) begin : gSticky
        logic [WIDTH-1:0] stk_q, stk_d;

        // A clear wipes only what was accumulated before; a same-cycle delivery still lands.
        always_comb begin
            stk_d = CLR ? '0 : stk_q;
            if (delivery) begin
                stk_d = stk_d | Z;
            end
        end

        always_ff @(posedge CP or negedge CD) begin
            if (!CD) begin
                stk_q <= '0;
            end else begin
                stk_q <= stk_d;
            end
        end

        assign STK = stk_q;
        assign ANY = |stk_q;
    end else begin : gNoSticky
        logic unusedSticky;
        assign unusedSticky = CLR ^ delivery;
        assign STK = '0;
        assign ANY = 1'b0;
    end

endmodule
